// File: rtl/dma_read_requester.sv
// Host-memory read requester: splits a DMA read command into MRd requests on the RQ port
// and forwards matching RC completion beats as a tagged data stream.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a read command
// ISSUE | splitting the command into requests, one tag per request
// DRAIN | all requests issued, waiting for every tag to complete
// DONE  | one cycle; done/done_err pulse is registered from here
module dma_read_requester #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32,
    parameter int MAX_TAGS   = 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset_p,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [63:0]           cmd_addr,
    input  logic [15:0]           cmd_dw_len,
    input  logic [2:0]            cfg_max_read_req,
    input  logic                  rq_ready,
    output logic                  rq_valid,
    output logic [3:0]            rq_type,
    output logic                  rq_payload_sop,
    output logic                  rq_payload_last,
    output logic [63:0]           rq_addr,
    output logic [10:0]           rq_payload_dw_count,
    output logic [7:0]            rq_tag,
    output logic [2:0]            rq_tc,
    output logic [DATA_WIDTH-1:0] rq_payload,
    input  logic                  rc_valid,
    input  logic [7:0]            rc_tag,
    input  logic [DATA_WIDTH-1:0] rc_payload,
    input  logic [KEEP_WIDTH-1:0] rc_payload_dw_keep,
    input  logic                  rc_payload_last,
    input  logic                  rc_request_completed,
    input  logic [3:0]            rc_err_code,
    input  logic                  rc_posioned,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic [7:0]            out_tag,
    output logic                  out_last,
    output logic                  done,
    output logic                  done_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [63:0]           addr_q, src_addr;
    logic [15:0]           remaining, src_rem;
    logic                  err;
    logic [MAX_TAGS-1:0]   busy, busy_nxt;
    logic                  accept, issue, rq_fire, free_any, tag_busy, rc_free, rc_err;
    logic [7:0]            alloc_tag;
    logic [2:0]            mrrs_code;
    logic [10:0]           mrrs_dw, bound_dw, cap_dw, req_dw;

    assign cmd_ready       = (state == S_IDLE) && !user_reset_p;
    assign rq_type         = 4'b0000;
    assign rq_payload_sop  = rq_valid;
    assign rq_payload_last = rq_valid;
    assign rq_tc           = 3'd0;
    assign rq_payload      = '0;
    assign rq_fire         = rq_valid && rq_ready;

    // In IDLE the first request is computed straight from the command so it goes out next cycle.
    always_comb begin
        mrrs_code = (cfg_max_read_req > 3'd5) ? 3'd5 : cfg_max_read_req;
        mrrs_dw   = 11'd32 << mrrs_code;
        src_addr  = (state == S_IDLE) ? (cmd_addr & ~64'h3) : addr_q;
        src_rem   = (state == S_IDLE) ? cmd_dw_len : remaining;
        bound_dw  = 11'd1024 - {1'b0, src_addr[11:2]};
        cap_dw    = (mrrs_dw < bound_dw) ? mrrs_dw : bound_dw;
        req_dw    = (src_rem < {5'd0, cap_dw}) ? src_rem[10:0] : cap_dw;
    end

    always_comb begin
        alloc_tag = 8'd0;
        free_any  = 1'b0;
        tag_busy  = 1'b0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any  = 1'b1;
                alloc_tag = 8'(i);
            end
        end
        for (int i = 0; i < MAX_TAGS; i++) begin
            if (rc_valid && rc_tag == 8'(i) && busy[i]) tag_busy = 1'b1;
        end
        rc_free = tag_busy && rc_payload_last && rc_request_completed;
        rc_err  = rc_valid && ((rc_err_code != 4'd0) || rc_posioned || !tag_busy);
        busy_nxt = busy;
        for (int i = 0; i < MAX_TAGS; i++) begin
            if (rq_fire && rq_tag == 8'(i)) busy_nxt[i] = 1'b1;
            if (rc_free && rc_tag == 8'(i)) busy_nxt[i] = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_dw_len != 16'd0) begin
                        issue     = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (rq_fire && remaining == {5'd0, rq_payload_dw_count}) state_nxt = S_DRAIN;
                else if (!rq_valid && free_any) issue = 1'b1;
            end
            S_DRAIN: if (busy == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset_p) begin
            state               <= S_IDLE;
            addr_q              <= '0;
            remaining           <= '0;
            err                 <= 1'b0;
            busy                <= '0;
            rq_valid            <= 1'b0;
            rq_addr             <= '0;
            rq_payload_dw_count <= '0;
            rq_tag              <= '0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            out_keep            <= '0;
            out_tag             <= '0;
            out_last            <= 1'b0;
            done                <= 1'b0;
            done_err            <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            if (accept) begin
                addr_q    <= cmd_addr & ~64'h3;
                remaining <= cmd_dw_len;
            end
            if (accept)      err <= 1'b0;
            else if (rc_err) err <= 1'b1;
            if (rq_fire) begin
                rq_valid  <= 1'b0;
                addr_q    <= rq_addr + 64'({rq_payload_dw_count, 2'b00});
                remaining <= remaining - {5'd0, rq_payload_dw_count};
            end else if (issue) begin
                rq_valid            <= 1'b1;
                rq_addr             <= src_addr;
                rq_payload_dw_count <= req_dw;
                rq_tag              <= alloc_tag;
            end
            out_valid <= tag_busy;
            if (tag_busy) begin
                out_data <= rc_payload;
                out_keep <= rc_payload_dw_keep;
                out_tag  <= rc_tag;
                out_last <= rc_payload_last && rc_request_completed;
            end
            done     <= (state == S_DONE);
            done_err <= (state == S_DONE) && err;
        end
    end

endmodule
